// File: rtl/pixel_mem_pkg.sv
// Shared definitions for the frame-buffer pixel layout, used by the write path,
// the read path and their benches: 3 bytes per pixel, R first, in raster order.
package pixel_mem_pkg;

    localparam int BYTES_PER_PX = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PIX,
        ST_WR_R,
        ST_WR_G,
        ST_WR_B,
        ST_DONE
    } wr_state_t;

    function automatic logic [31:0] px_addr(
        input logic [31:0] base,
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] w
    );
        return base + BYTES_PER_PX * (y * w + x);
    endfunction

endpackage

// File: rtl/pixel_frame_writer_raster_counter.sv
// Raster-order x/y position counter: clears to (0,0), advances one pixel per
// request and wraps back to (0,0) after the last pixel of the frame.
module raster_counter #(
    parameter int IMG_W = 900,
    parameter int IMG_H = 300,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// Stores a raster-ordered 24-bit RGB stream into byte-addressed memory as three
// consecutive bytes (R, G, B) at frame_base + 3*(y*IMG_W + x).
module pixel_frame_writer
    import pixel_mem_pkg::*;
#(
    parameter int IMG_W  = 900,
    parameter int IMG_H  = 300,
    parameter int ADDR_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        frame_base,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [23:0]              s_pixel,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [7:0]               mem_wdata,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(IMG_W)-1:0] x_pos,
    output logic [$clog2(IMG_H)-1:0] y_pos
);

    wr_state_t         state_q;
    logic [ADDR_W-1:0] ptr_q;
    rgb_t              pix_q;
    rgb_t              px_in;
    logic              s_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              last_px;
    logic              raster_clear;
    logic              raster_advance;

    assign px_in          = s_pixel;
    assign raster_clear   = (state_q == ST_IDLE) && start;
    assign raster_advance = (state_q == ST_WR_B) && mem_ready;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (raster_clear),
        .advance_i (raster_advance),
        .x_o       (x_pos),
        .y_o       (y_pos),
        .last_o    (last_px)
    );

    assign s_ready    = s_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // ptr_q is a running byte pointer: it always holds the R address of the pending pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            pix_q        <= '0;
            s_ready_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_q     <= frame_base;
                        busy_q    <= 1'b1;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_WAIT_PIX;
                    end
                end
                ST_WAIT_PIX: begin
                    if (s_valid) begin
                        pix_q       <= px_in;
                        s_ready_q   <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= px_in.r;
                        state_q     <= ST_WR_R;
                    end
                end
                ST_WR_R: begin
                    if (mem_ready) begin
                        mem_addr_q  <= ptr_q + ADDR_W'(1);
                        mem_wdata_q <= pix_q.g;
                        state_q     <= ST_WR_G;
                    end else begin
                        mem_wdata_q <= pix_q.r;
                    end
                end
                ST_WR_G: begin
                    if (mem_ready) begin
                        mem_addr_q  <= ptr_q + ADDR_W'(2);
                        mem_wdata_q <= pix_q.b;
                        state_q     <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (mem_ready) begin
                        mem_we_q <= 1'b0;
                        ptr_q    <= ptr_q + ADDR_W'(BYTES_PER_PX);
                        if (last_px) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            s_ready_q <= 1'b1;
                            state_q   <= ST_WAIT_PIX;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer on a 4x2 frame, plus a second instance
// with an 8-bit address bus to exercise byte-address wrap.
`timescale 1ns/1ps
module tb_pixel_frame_writer;
    import pixel_mem_pkg::*;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int AW     = 12;
    localparam int NBYTES = BYTES_PER_PX * W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, start, s_valid, s_ready, mem_we, mem_ready, busy, frame_done;
    logic [AW-1:0]          frame_base, mem_addr;
    logic [23:0]            s_pixel;
    logic [7:0]             mem_wdata;
    logic [$clog2(W)-1:0]   x_pos;
    logic [$clog2(H)-1:0]   y_pos;

    logic                   w_start, w_s_valid, w_s_ready, w_mem_we, w_mem_ready, w_busy, w_frame_done;
    logic [7:0]             w_frame_base, w_mem_addr, w_mem_wdata;
    logic [23:0]            w_s_pixel;
    logic [$clog2(W)-1:0]   w_x_pos;
    logic [$clog2(H)-1:0]   w_y_pos;

    pixel_frame_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .frame_done(frame_done), .x_pos(x_pos), .y_pos(y_pos)
    );

    pixel_frame_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(8)) dut_wrap (
        .clk(clk), .rst(rst), .start(w_start), .frame_base(w_frame_base),
        .s_valid(w_s_valid), .s_ready(w_s_ready), .s_pixel(w_s_pixel),
        .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_ready(w_mem_ready),
        .busy(w_busy), .frame_done(w_frame_done), .x_pos(w_x_pos), .y_pos(w_y_pos)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log of every byte the memory accepts, plus frame_done pulse count.
    logic [AW-1:0] log_addr[$];
    logic [7:0]    log_data[$];
    int            log_cyc[$];
    int            done_pulses = 0;

    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
        end
        if (frame_done) done_pulses++;
    end

    logic [AW-1:0]        gold_addr[NBYTES];
    logic [7:0]           gold_data[NBYTES];
    logic [$clog2(W)-1:0] xs[W*H];
    logic [$clog2(H)-1:0] ys[W*H];
    int lb, db, done_cyc, bp_cycles, bp_bad, stall_cycles, stall_bad, stall_go_cyc;
    bit timed_out;
    logic busy_after, done_after, sready_after;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame of pixels 0x0A0B0C+k with optional backpressure on the G byte of
    // pixel bp_k, a 5-cycle source stall before pixel stall_k and an extra start at ign_k.
    task automatic drive_frame(input logic [AW-1:0] base, input int bp_k, input int stall_k,
                               input int ign_k, input bit start_on_done);
        int k, bp_left, stall_left;
        bit bp_used, stall_used, ign_used, stall_go_set, accepted;
        k = 0; bp_left = 0; stall_left = 0;
        bp_used = 0; stall_used = 0; ign_used = 0; stall_go_set = 0;
        bp_cycles = 0; bp_bad = 0; stall_cycles = 0; stall_bad = 0; stall_go_cyc = -1;
        timed_out = 1'b1;
        lb = log_addr.size();
        db = done_pulses;
        mem_ready = 1'b1; s_valid = 1'b0;
        start = 1'b1; frame_base = base;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (frame_done) begin
                timed_out = 1'b0;
                break;
            end
            s_pixel = 24'h0A0B0C + 24'(k);
            start = (ign_k >= 0 && !ign_used && k == ign_k);
            if (start) begin
                ign_used   = 1'b1;
                frame_base = AW'(12'h300);
            end
            if (bp_k >= 0 && !bp_used && mem_we && mem_addr == AW'(base + 3 * bp_k + 1)) begin
                bp_used = 1'b1;
                bp_left = 3;
            end
            if (bp_left > 0) begin
                mem_ready = 1'b0;
                bp_left--;
                bp_cycles++;
                if (mem_addr !== AW'(base + 3 * bp_k + 1) || mem_wdata !== 8'h0B || s_ready !== 1'b0)
                    bp_bad++;
            end else begin
                mem_ready = 1'b1;
            end
            if (stall_k >= 0 && !stall_used && s_ready && k == stall_k) begin
                stall_used = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                s_valid = 1'b0;
                stall_left--;
                stall_cycles++;
                if (mem_we !== 1'b0 || s_ready !== 1'b1) stall_bad++;
            end else begin
                s_valid = 1'b1;
                if (stall_used && !stall_go_set) begin
                    stall_go_set = 1'b1;
                    stall_go_cyc = cyc;
                end
            end
            accepted = s_valid && s_ready;
            if (accepted && k < W * H) begin
                xs[k] = x_pos;
                ys[k] = y_pos;
            end
            tick();
            if (accepted) k++;
        end
        start = 1'b0;
        done_cyc = cyc;
        start = start_on_done;
        tick();
        start = 1'b0;
        busy_after   = busy;
        done_after   = frame_done;
        sready_after = s_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_pixel = '0; mem_ready = 1'b0; frame_base = '0;
        w_start = 1'b0; w_s_valid = 1'b0; w_s_pixel = '0; w_mem_ready = 1'b0; w_frame_base = '0;
        tick(); tick(); tick();
        n_cmp++; if (s_ready !== 1'b0)    begin n_bad++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
        n_cmp++; if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        n_cmp++; if (mem_addr !== '0)     begin n_bad++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
        n_cmp++; if (mem_wdata !== '0)    begin n_bad++; $display("FAIL reset_mem_wdata: got %h, required 0", mem_wdata); end
        n_cmp++; if (x_pos !== '0 || y_pos !== '0)
            begin n_bad++; $display("FAIL reset_xy: got x=%0d y=%0d, required 0,0", x_pos, y_pos); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        int nw;
        for (int i = 0; i < NBYTES; i++) begin
            gold_addr[i] = AW'(px_addr(32'h100, 32'((i / 3) % W), 32'((i / 3) / W), 32'(W)) + 32'(i % 3));
            gold_data[i] = (i % 3 == 0) ? 8'h0A : (i % 3 == 1) ? 8'h0B : 8'(8'h0C + i / 3);
        end
        drive_frame(AW'(12'h100), -1, -1, -1, 1'b0);
        nw = log_addr.size() - lb;
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout: got no frame_done in 400 cycles, required one"); end
        n_cmp++; if (nw !== NBYTES) begin n_bad++; $display("FAIL basic_count: got %0d writes, required %0d", nw, NBYTES); end
        for (int i = 0; i < NBYTES && i < nw; i++) begin
            n_cmp++;
            if (log_addr[lb + i] !== gold_addr[i] || log_data[lb + i] !== gold_data[i]) begin
                n_bad++;
                $display("FAIL basic_byte[%0d]: got %h=%h, required %h=%h", i,
                         log_addr[lb + i], log_data[lb + i], gold_addr[i], gold_data[i]);
            end
        end
        n_cmp++; if (done_pulses - db !== 1)
            begin n_bad++; $display("FAIL basic_done_pulses: got %0d, required 1", done_pulses - db); end
        if (nw > 0) begin
            n_cmp++;
            if (done_cyc !== log_cyc[lb + nw - 1] + 1) begin
                n_bad++;
                $display("FAIL basic_done_timing: got cycle %0d, required %0d", done_cyc, log_cyc[lb + nw - 1] + 1);
            end
        end
        n_cmp++; if (busy_after !== 1'b0 || done_after !== 1'b0)
            begin n_bad++; $display("FAIL basic_busy_fall: got busy=%b done=%b, required 0,0", busy_after, done_after); end
        n_cmp++; if (x_pos !== '0 || y_pos !== '0)
            begin n_bad++; $display("FAIL basic_xy_wrap: got x=%0d y=%0d, required 0,0", x_pos, y_pos); end
    endtask

    task automatic test_backpressure();
        int nw;
        drive_frame(AW'(12'h100), 1, -1, -1, 1'b0);
        nw = log_addr.size() - lb;
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout: got no frame_done, required one"); end
        n_cmp++; if (bp_cycles !== 3) begin n_bad++; $display("FAIL bp_cycles: got %0d, required 3", bp_cycles); end
        n_cmp++; if (bp_bad !== 0)
            begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles, required 0 (addr 104, data 0B, s_ready 0)", bp_bad); end
        n_cmp++; if (nw !== NBYTES) begin n_bad++; $display("FAIL bp_count: got %0d writes, required %0d", nw, NBYTES); end
        for (int i = 0; i < NBYTES && i < nw; i++) begin
            n_cmp++;
            if (log_addr[lb + i] !== gold_addr[i] || log_data[lb + i] !== gold_data[i]) begin
                n_bad++;
                $display("FAIL bp_byte[%0d]: got %h=%h, required %h=%h", i,
                         log_addr[lb + i], log_data[lb + i], gold_addr[i], gold_data[i]);
            end
        end
    endtask

    task automatic test_row_wrap();
        int nw;
        drive_frame(AW'(12'h100), -1, -1, -1, 1'b0);
        nw = log_addr.size() - lb;
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL wrap_timeout: got no frame_done, required one"); end
        for (int k = 0; k < W * H; k++) begin
            n_cmp++;
            if (xs[k] !== ($clog2(W))'(k % W) || ys[k] !== ($clog2(H))'(k / W)) begin
                n_bad++;
                $display("FAIL wrap_xy[%0d]: got x=%0d y=%0d, required x=%0d y=%0d", k, xs[k], ys[k], k % W, k / W);
            end
        end
        n_cmp++; if (nw <= 12 || log_addr[lb + 12] !== AW'(12'h10C))
            begin n_bad++; $display("FAIL wrap_row1_addr: got %0d writes / addr %h, required addr 10C", nw, nw > 12 ? log_addr[lb + 12] : '0); end
    endtask

    task automatic test_source_stall();
        int nw;
        drive_frame(AW'(12'h100), -1, 2, -1, 1'b0);
        nw = log_addr.size() - lb;
        n_cmp++; if (stall_cycles !== 5) begin n_bad++; $display("FAIL stall_cycles: got %0d, required 5", stall_cycles); end
        n_cmp++; if (stall_bad !== 0)
            begin n_bad++; $display("FAIL stall_idle: got %0d bad cycles, required 0 (mem_we 0, s_ready 1)", stall_bad); end
        n_cmp++; if (nw !== NBYTES) begin n_bad++; $display("FAIL stall_count: got %0d writes, required %0d", nw, NBYTES); end
        if (nw > 6) begin
            n_cmp++;
            if (log_addr[lb + 6] !== AW'(12'h106) || log_cyc[lb + 6] !== stall_go_cyc + 1) begin
                n_bad++;
                $display("FAIL stall_accept: got addr %h at cycle %0d, required addr 106 at cycle %0d",
                         log_addr[lb + 6], log_cyc[lb + 6], stall_go_cyc + 1);
            end
        end
    endtask

    task automatic test_ignored_start();
        int nw;
        drive_frame(AW'(12'h100), -1, -1, 3, 1'b1);
        nw = log_addr.size() - lb;
        n_cmp++; if (nw !== NBYTES) begin n_bad++; $display("FAIL ign_count: got %0d writes, required %0d", nw, NBYTES); end
        for (int i = 0; i < NBYTES && i < nw; i++) begin
            n_cmp++;
            if (log_addr[lb + i] !== gold_addr[i] || log_data[lb + i] !== gold_data[i]) begin
                n_bad++;
                $display("FAIL ign_byte[%0d]: got %h=%h, required %h=%h", i,
                         log_addr[lb + i], log_data[lb + i], gold_addr[i], gold_data[i]);
            end
        end
        n_cmp++; if (busy_after !== 1'b0 || sready_after !== 1'b0)
            begin n_bad++; $display("FAIL ign_done_start: got busy=%b s_ready=%b, required 0,0", busy_after, sready_after); end
        tick();
        n_cmp++; if (busy !== 1'b0 || mem_we !== 1'b0 || done_pulses - db !== 1)
            begin n_bad++; $display("FAIL ign_idle: got busy=%b mem_we=%b pulses=%0d, required 0,0,1", busy, mem_we, done_pulses - db); end
    endtask

    task automatic test_mid_reset();
        int k, nw;
        bit found, acc;
        k = 0; found = 1'b0;
        lb = log_addr.size();
        mem_ready = 1'b1; s_valid = 1'b1;
        start = 1'b1; frame_base = AW'(12'h100);
        tick();
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            s_pixel = 24'h0A0B0C + 24'(k);
            if (mem_we && mem_addr == AW'(12'h108)) begin
                found = 1'b1;
                break;
            end
            acc = s_valid && s_ready;
            tick();
            if (acc) k++;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid_reach: got no B write of pixel 2, required one"); end
        mem_ready = 1'b0; s_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (mem_we !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || frame_done !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_ctrl: got we=%b busy=%b rdy=%b done=%b, required all 0", mem_we, busy, s_ready, frame_done); end
        n_cmp++; if (x_pos !== '0 || y_pos !== '0)
            begin n_bad++; $display("FAIL rstmid_xy: got x=%0d y=%0d, required 0,0", x_pos, y_pos); end
        n_cmp++; if (log_addr.size() - lb !== 8)
            begin n_bad++; $display("FAIL rstmid_partial: got %0d writes, required 8", log_addr.size() - lb); end
        drive_frame(AW'(12'h200), -1, -1, -1, 1'b0);
        nw = log_addr.size() - lb;
        n_cmp++; if (nw !== NBYTES) begin n_bad++; $display("FAIL rstmid_count: got %0d writes, required %0d", nw, NBYTES); end
        if (nw == NBYTES) begin
            n_cmp++;
            if (log_addr[lb] !== AW'(12'h200) || log_data[lb] !== 8'h0A || log_addr[lb + NBYTES - 1] !== AW'(12'h217)) begin
                n_bad++;
                $display("FAIL rstmid_restart: got first %h=%h last %h, required first 200=0A last 217",
                         log_addr[lb], log_data[lb], log_addr[lb + NBYTES - 1]);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] wa[NBYTES];
        logic [7:0] wd[NBYTES];
        logic [7:0] ea, ed;
        int k, n;
        bit seen, acc;
        k = 0; n = 0; seen = 1'b0;
        w_mem_ready = 1'b1; w_s_valid = 1'b1;
        w_start = 1'b1; w_frame_base = 8'hFA;
        tick();
        w_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (w_frame_done) begin
                seen = 1'b1;
                break;
            end
            w_s_pixel = 24'h0A0B0C + 24'(k);
            if (w_mem_we) begin
                if (n < NBYTES) begin
                    wa[n] = w_mem_addr;
                    wd[n] = w_mem_wdata;
                end
                n++;
            end
            acc = w_s_valid && w_s_ready;
            tick();
            if (acc) k++;
        end
        w_s_valid = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL awrap_timeout: got no frame_done, required one"); end
        n_cmp++; if (n !== NBYTES) begin n_bad++; $display("FAIL awrap_count: got %0d writes, required %0d", n, NBYTES); end
        for (int i = 0; i < 9 && i < n; i++) begin
            ea = 8'(px_addr(32'hFA, 32'((i / 3) % W), 32'((i / 3) / W), 32'(W)) + 32'(i % 3));
            ed = (i % 3 == 0) ? 8'h0A : (i % 3 == 1) ? 8'h0B : 8'(8'h0C + i / 3);
            n_cmp++;
            if (wa[i] !== ea || wd[i] !== ed) begin
                n_bad++;
                $display("FAIL awrap_byte[%0d]: got %h=%h, required %h=%h", i, wa[i], wd[i], ea, ed);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_row_wrap();
        test_source_stall();
        test_ignored_start();
        test_mid_reset();
        test_addr_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
